// File: rtl/hazard_detection_unit.sv
// Decode-stage hazard detector: load-use and branch-operand stalls, memory-wait freeze, taken-branch flush.
// Outputs are combinational from state and inputs (zero latency); mem_ready=0 freezes everything including the stall sequence.
module hazard_detection_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_EX_MemRead,
    input  logic        ID_EX_RegWrite,
    input  logic [4:0]  ID_EX_RegisterRt,
    input  logic [4:0]  ID_EX_RegisterRd,
    input  logic        EX_MEM_MemRead,
    input  logic [4:0]  EX_MEM_RegisterRd,
    input  logic [4:0]  IF_ID_RegisterRs,
    input  logic [4:0]  IF_ID_RegisterRt,
    input  logic        IF_ID_UsesRt,
    input  logic        ID_Branch,
    input  logic        BranchTaken,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        ID_EX_Bubble,
    output logic        IF_ID_Flush,
    output logic        Freeze,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_WAIT} state_t;

    state_t     state, stateNext, savedState, savedNext, effState;
    logic [1:0] cnt, cntNext;
    logic       luHit, baHit, bl2Hit, bl1Hit;

    // Register 0 is hardwired to zero, so it never creates a dependence.
    always_comb begin
        luHit  = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                 ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                  (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));
        baHit  = ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0) &&
                 ((ID_EX_RegisterRd == IF_ID_RegisterRs) || (ID_EX_RegisterRd == IF_ID_RegisterRt));
        bl2Hit = ID_Branch && ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                 ((ID_EX_RegisterRt == IF_ID_RegisterRs) || (ID_EX_RegisterRt == IF_ID_RegisterRt));
        bl1Hit = ID_Branch && EX_MEM_MemRead && (EX_MEM_RegisterRd != 5'd0) &&
                 ((EX_MEM_RegisterRd == IF_ID_RegisterRs) || (EX_MEM_RegisterRd == IF_ID_RegisterRt));
    end

    // On the first ready cycle out of WAIT, behave as the saved state so no cycle is lost.
    assign effState = (state == S_WAIT) ? savedState : state;

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        Freeze       = 1'b0;
        stateNext    = state;
        savedNext    = savedState;
        cntNext      = cnt;
        if (reset) begin
            stateNext = S_RUN;
        end else if (!mem_ready) begin
            Freeze      = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            stateNext   = S_WAIT;
            if (state != S_WAIT)
                savedNext = state;
        end else begin
            case (effState)
                S_STALL: begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    cntNext      = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
                    stateNext    = (cnt <= 2'd1) ? S_RUN : S_STALL;
                end
                default: begin
                    stateNext = S_RUN;
                    if (bl2Hit || luHit || baHit || bl1Hit) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                        if (bl2Hit) begin
                            cntNext   = 2'd1;
                            stateNext = S_STALL;
                        end
                    end else begin
                        IF_ID_Flush = ID_Branch & BranchTaken;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            savedState  <= S_RUN;
            cnt         <= 2'd0;
            stall_count <= 16'd0;
        end else begin
            state      <= stateNext;
            savedState <= savedNext;
            cnt        <= cntNext;
            if (ID_EX_Bubble && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: expected outputs queued per driven cycle, compared mid-cycle.
module tb_hazard_detection_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_EX_MemRead, ID_EX_RegWrite;
    logic [4:0]  ID_EX_RegisterRt, ID_EX_RegisterRd;
    logic        EX_MEM_MemRead;
    logic [4:0]  EX_MEM_RegisterRd;
    logic [4:0]  IF_ID_RegisterRs, IF_ID_RegisterRt;
    logic        IF_ID_UsesRt, ID_Branch, BranchTaken, mem_ready;
    logic        PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Freeze;
    logic [15:0] stall_count;

    hazard_detection_unit dut (
        .clk(clk), .reset(reset),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_RegisterRt(ID_EX_RegisterRt), .ID_EX_RegisterRd(ID_EX_RegisterRd),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_RegisterRd(EX_MEM_RegisterRd),
        .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
        .IF_ID_UsesRt(IF_ID_UsesRt), .ID_Branch(ID_Branch), .BranchTaken(BranchTaken),
        .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
        .IF_ID_Flush(IF_ID_Flush), .Freeze(Freeze), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Output vector order: {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Freeze}
    localparam logic [4:0] NORM  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00100;
    localparam logic [4:0] FRZ   = 5'b00001;
    localparam logic [4:0] FLUSH = 5'b11010;

    typedef struct packed {
        logic [4:0]  outs;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    string       tagq[$];
    exp_t        monExp;
    string       monTag;
    logic [15:0] expCnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            monExp = sb.pop_front();
            monTag = tagq.pop_front();
            check_val({monTag, "_outs"},
                      {27'd0, PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Freeze},
                      {27'd0, monExp.outs});
            check_val({monTag, "_cnt"}, {16'd0, stall_count}, {16'd0, monExp.cnt});
        end
    end

    // Inputs are already set; queue the expectation, then advance one cycle.
    task automatic step(input string tag, input logic [4:0] outs);
        exp_t e;
        e.outs = outs;
        e.cnt  = expCnt;
        sb.push_back(e);
        tagq.push_back(tag);
        if (reset)
            expCnt = 16'd0;
        else if (outs[2] && expCnt != 16'hFFFF)
            expCnt = expCnt + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_RegisterRt = 0; ID_EX_RegisterRd = 0;
        EX_MEM_MemRead = 0; EX_MEM_RegisterRd = 0; IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0;
        IF_ID_UsesRt = 0; ID_Branch = 0; BranchTaken = 0; mem_ready = 1;
    endtask

    task automatic set_bl2();
        ID_Branch = 1; BranchTaken = 1; ID_EX_MemRead = 1; ID_EX_RegisterRt = 5'd8;
        IF_ID_RegisterRs = 5'd8;
    endtask

    initial begin
        clear_in();
        reset  = 1;
        expCnt = 16'd0;
        @(posedge clk);
        #1;
        step("rst_forced", NORM);
        reset = 0;
        step("idle", NORM);

        // Load-use on rs
        ID_EX_MemRead = 1; ID_EX_RegisterRt = 5'd10; IF_ID_RegisterRs = 5'd10;
        step("lu_rs", STALL);
        clear_in();
        step("lu_after", NORM);

        // Register 0 and UsesRt qualification
        ID_EX_MemRead = 1; IF_ID_UsesRt = 1;
        step("lu_zero", NORM);
        ID_EX_RegisterRt = 5'd5; IF_ID_RegisterRt = 5'd5; IF_ID_RegisterRs = 5'd3; IF_ID_UsesRt = 0;
        step("lu_rt_unused", NORM);
        IF_ID_UsesRt = 1;
        step("lu_rt_used", STALL);
        clear_in();

        // Branch on ALU result in EX, then a taken branch with no hazard
        ID_Branch = 1; ID_EX_RegWrite = 1; ID_EX_RegisterRd = 5'd7; IF_ID_RegisterRt = 5'd7;
        BranchTaken = 1;
        step("ba", STALL);
        ID_EX_RegWrite = 0;
        step("ba_flush", FLUSH);
        clear_in();

        // Branch on load in MEM
        ID_Branch = 1; EX_MEM_MemRead = 1; EX_MEM_RegisterRd = 5'd9; IF_ID_RegisterRs = 5'd9;
        step("bl1", STALL);
        clear_in();
        step("bl1_after", NORM);

        // Branch on load in EX: two bubbles, flush held off until the third cycle
        set_bl2();
        step("bl2_b1", STALL);
        ID_EX_MemRead = 0; ID_EX_RegisterRt = 0;
        step("bl2_b2", STALL);
        step("bl2_flush", FLUSH);
        clear_in();

        // Freeze between the two BL2 bubbles
        set_bl2();
        step("frz_b1", STALL);
        clear_in();
        mem_ready = 0; BranchTaken = 1; ID_Branch = 1;
        for (int i = 0; i < 3; i++) step("frz_hold", FRZ);
        mem_ready = 1;
        step("frz_b2", STALL);
        step("frz_resume", FLUSH);
        clear_in();

        // Freeze overrides a hazard detected in RUN
        ID_EX_MemRead = 1; ID_EX_RegisterRt = 5'd4; IF_ID_RegisterRs = 5'd4; mem_ready = 0;
        step("frz_over_lu", FRZ);
        mem_ready = 1;
        step("lu_after_frz", STALL);
        clear_in();

        // Reset in STALL aborts the second bubble
        set_bl2();
        step("rs_b1", STALL);
        clear_in();
        reset = 1;
        step("rs_forced", NORM);
        reset = 0; ID_Branch = 1; BranchTaken = 1;
        step("rs_run", FLUSH);
        clear_in();

        // Reset while frozen in WAIT with a pending BL2 bubble
        set_bl2();
        step("rw_b1", STALL);
        clear_in();
        mem_ready = 0;
        step("rw_frz", FRZ);
        reset = 1;
        step("rw_forced", NORM);
        reset = 0; mem_ready = 1;
        step("rw_run", NORM);

        // Saturation: preload with back-to-back load-use stalls
        ID_EX_MemRead = 1; ID_EX_RegisterRt = 5'd2; IF_ID_RegisterRs = 5'd2;
        reset = 1;
        step("sat_rst", STALL & 5'b00000 | NORM);
        reset = 0;
        repeat (65535) @(posedge clk);
        #1;
        expCnt = 16'hFFFF;
        step("sat_1", STALL);
        step("sat_2", STALL);
        clear_in();
        step("sat_hold", NORM);

        check_val("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Decode-stage hazard detector and stall sequencer for the 5-stage MIPS pipeline. It is the counterpart of the forwarding unit: forwarding resolves dependences by routing results forward into EX, and this block handles the dependences forwarding cannot cover by holding PC and IF/ID and inserting bubbles into ID/EX. It also freezes the pipeline on data-memory wait and flushes IF/ID on taken branches. It keeps a saturating stall-cycle performance counter.

## Interface
- No parameters; register specifiers are fixed at 5 bits and the counter at 16 bits.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RegWrite  in  1  instruction in EX writes a register.
- ID_EX_RegisterRt  in  5  load destination in EX.
- ID_EX_RegisterRd  in  5  ALU destination in EX, post RegDst mux.
- EX_MEM_MemRead  in  1  instruction in MEM is a load.
- EX_MEM_RegisterRd  in  5  destination in MEM.
- IF_ID_RegisterRs  in  5  rs of the instruction in ID.
- IF_ID_RegisterRt  in  5  rt of the instruction in ID.
- IF_ID_UsesRt  in  1  the ID instruction reads rt as a source.
- ID_Branch  in  1  the ID instruction is beq/bne; it is compared in ID.
- BranchTaken  in  1  the ID-stage comparator result.
- mem_ready  in  1  data memory is ready; 0 means freeze.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID update enable.
- ID_EX_Bubble  out  1  zero the ID/EX control fields this cycle.
- IF_ID_Flush  out  1  clear IF/ID (taken branch).
- Freeze  out  1  hold all pipeline registers.
- stall_count  out  16  saturating count of bubble cycles.

## Operation
- Hazard conditions are evaluated only in state RUN. A register specifier equal to 0 never matches.
  - **LU, load-use:** ID_EX_MemRead, and ID_EX_RegisterRt equals either IF_ID_RegisterRs, or IF_ID_RegisterRt when IF_ID_UsesRt is 1. LU requires 1 bubble.
  - **BA, branch on ALU result in EX:** ID_Branch and ID_EX_RegWrite and !ID_EX_MemRead, and ID_EX_RegisterRd equals rs or rt. BA requires 1 bubble.
  - **BL2, branch on load in EX:** ID_Branch and ID_EX_MemRead, and ID_EX_RegisterRt equals rs or rt. BL2 requires 2 bubbles.
  - **BL1, branch on load in MEM:** ID_Branch and EX_MEM_MemRead, and EX_MEM_RegisterRd equals rs or rt. BL1 requires 1 bubble.
  - N = the maximum over all true conditions. When LU and BL2 are both true, N = 2.
- The state machine has three states, encoded in a state register plus a 2-bit cnt.
  - **RUN:** When N > 0, assert the stall in this cycle (Mealy). If N = 1, stay in RUN. If N = 2, load cnt = 1 and go to STALL.
  - **STALL:** Assert the stall unconditionally; inputs are ignored. Decrement cnt. Go to RUN when cnt reaches 0.
  - **WAIT:** Entered whenever mem_ready = 0, from either state. The prior state and cnt are saved. Return to the saved state on the first cycle with mem_ready = 1.
- Stall outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
- Freeze outputs apply whenever mem_ready = 0, in any state, and take priority over everything else: Freeze=1, PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=0, IF_ID_Flush=0. The state, cnt and stall_count do not change while frozen.
- Normal outputs, in RUN with no hazard: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, Freeze=0, IF_ID_Flush = ID_Branch & BranchTaken.
- BranchTaken is ignored during any stall cycle, because its operands are stale.
- stall_count increments by 1 on every clock edge where ID_EX_Bubble = 1. It saturates at 16'hFFFF.

## Timing
- All hazard outputs are combinational from the state and the inputs, with zero latency. The state, cnt and stall_count update on the rising edge.
- While reset = 1, outputs are forced to PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, Freeze=0.
- On the next edge after reset: state=RUN, cnt=0, stall_count=0.
- Reset asserted in the middle of a STALL or WAIT aborts it; the block is in RUN after the edge.
- Bubble counts are measured from the detection cycle: LU, BA and BL1 give 1 cycle; BL2 gives 2 consecutive cycles. A freeze between the two BL2 bubbles delays, but does not cancel, the second bubble.
- The stall is asserted combinationally in the detection cycle and does not wait for a clock edge.

## Test plan
- **Load-use:** lw $t2 in EX (MemRead=1, Rt=10), ID instruction with rs=10 -> exactly 1 cycle of PCWrite=0, ID_EX_Bubble=1; stall_count goes from 0 to 1; normal outputs resume.
- **Specifier 0 and UsesRt:** ID_EX_RegisterRt=0 with rs=0 -> no stall. Rt match with IF_ID_UsesRt=0 -> no stall.
- **Branch on loaded value:** beq with rs=8 while lw with Rt=8 is in EX -> 2 consecutive bubbles and stall_count=2. BranchTaken=1 during both bubbles -> IF_ID_Flush stays 0. On the third cycle with BranchTaken=1 -> IF_ID_Flush=1.
- **Freeze mid-stall:** mem_ready=0 during the second BL2 bubble for 3 cycles -> Freeze=1 and ID_EX_Bubble=0 for those 3 cycles; after mem_ready returns, exactly 1 bubble remains; stall_count ends at 2.
- **Reset:** reset asserted in STALL -> the next cycle is in RUN with cnt=0 and stall_count=0; the outputs forced while reset is high are checked.
- **Saturation:** preload via 65,535 forced stall cycles, then add 2 more -> stall_count holds at 16'hFFFF.
